sram_ctrl: RTL and testbench

- Sequencer and arbiter in front of the 128 x 32-bit pulse-driven SRAM macro.
- Accepts single-word transactions from two clocked requesters, port 0 (instruction fetch, read-only) and port 1 (load/store, read/write).
- Drives the macro's addr_sel, byte_sel, datain, read_pulse and write_pulse with a fixed setup/pulse/recover timing.
- Returns read data or completion with an error flag through a one-cycle response strobe per port.

---
 rtl/sram_ctrl_pkg.sv | 23 ++
 rtl/sram_byte_mask.sv | 35 +++
 rtl/sram_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_sram_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and encodings for the SRAM sequencer/arbiter.
package sram_ctrl_pkg;

    // Sequencer states: normal access runs SETUP -> PULSE -> RECOVER,
    // rejected requests take the single-cycle ERRRESP detour.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        PULSE   = 3'd2,
        RECOVER = 3'd3,
        ERRRESP = 3'd4
    } state_e;

    // Port 1 access size encodings (2'b11 is illegal).
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Requester indices, also the encoding of the round-robin pointer.
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

endpackage

// File: rtl/sram_byte_mask.sv
// Byte-lane mask generation plus alignment and range checking for one access.
module sram_byte_mask
    import sram_ctrl_pkg::*;
#(
    parameter int DEPTH_WORDS = 128
) (
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [29:0] word_idx_i,
    output logic [3:0]  mask_o,
    output logic        misaligned_o,
    output logic        out_of_range_o
);

    // Lane mask and alignment follow directly from size and the low address bits.
    always_comb begin
        mask_o       = 4'b0000;
        misaligned_o = 1'b0;
        case (size_i)
            SZ_BYTE: mask_o = 4'b0001 << addr_lo_i;
            SZ_HALF: begin
                mask_o       = 4'b0011 << addr_lo_i;
                misaligned_o = addr_lo_i[0];
            end
            SZ_WORD: begin
                mask_o       = 4'b1111;
                misaligned_o = (addr_lo_i != 2'b00);
            end
            default: misaligned_o = 1'b1;
        endcase
    end

    assign out_of_range_o = (word_idx_i >= 30'(DEPTH_WORDS));

endmodule

// File: rtl/sram_ctrl.sv
// Two-port arbiter and setup/pulse/recover sequencer for a pulse-driven SRAM macro.
// Handshake: a requester holds req and its operands until it sees gnt; gnt is
// combinational and only high in IDLE, and the operands are taken on the clock
// edge that ends the gnt cycle. Each accepted request gets exactly one rvalid
// strobe (unless reset intervenes); rdata/err hold between strobes.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int PULSE_CYCLES = 2,
    parameter int DEPTH_WORDS  = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [6:0]  sram_addr,
    output logic [3:0]  sram_byte_sel,
    output logic [31:0] sram_wdata,
    output logic        sram_read_pulse,
    output logic        sram_write_pulse,
    input  logic        sram_done,
    input  logic [31:0] sram_rdata,
    output logic [2:0]  dbg_state
);

    state_e      state_q, state_d;
    logic        rr_last_q, rr_last_d;
    logic        port_q, port_d;
    logic        we_q, we_d;
    logic [6:0]  addr_q, addr_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        if_err_q, if_err_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_err_q, d_err_d;

    logic        idle;
    logic        sel_port;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [3:0]  sel_mask;
    logic        sel_misaligned;
    logic        sel_oor;

    // Round-robin grant: on a tie the port that did not win last time goes.
    assign idle   = (state_q == IDLE);
    assign if_gnt = !reset && idle && if_req && !(d_req && (rr_last_q == PORT_IF));
    assign d_gnt  = !reset && idle && d_req && !(if_req && (rr_last_q == PORT_D));

    // Operand mux; port 0 is always a full-word read.
    assign sel_port = d_gnt ? PORT_D : PORT_IF;
    assign sel_size = d_gnt ? d_size : SZ_WORD;
    assign sel_addr = d_gnt ? d_addr : if_addr;

    sram_byte_mask #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_mask (
        .size_i        (sel_size),
        .addr_lo_i     (sel_addr[1:0]),
        .word_idx_i    (sel_addr[31:2]),
        .mask_o        (sel_mask),
        .misaligned_o  (sel_misaligned),
        .out_of_range_o(sel_oor)
    );

    // Next-state, operand capture and response generation.
    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        port_d      = port_q;
        we_d        = we_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_err_d    = if_err_q;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_err_d     = d_err_q;
        case (state_q)
            IDLE: begin
                if (if_gnt || d_gnt) begin
                    rr_last_d = sel_port;
                    port_d    = sel_port;
                    if (sel_misaligned || sel_oor) begin
                        // Rejected: answer next cycle without touching the macro.
                        state_d = ERRRESP;
                        if (sel_port == PORT_D) begin
                            d_rvalid_d = 1'b1;
                            d_rdata_d  = 32'h0;
                            d_err_d    = 1'b1;
                        end else begin
                            if_rvalid_d = 1'b1;
                            if_rdata_d  = 32'h0;
                            if_err_d    = 1'b1;
                        end
                    end else begin
                        state_d = SETUP;
                        we_d    = d_gnt && d_we;
                        addr_d  = sel_addr[8:2];
                        mask_d  = sel_mask;
                        wdata_d = d_gnt ? d_wdata : 32'h0;
                    end
                end
            end
            SETUP: begin
                state_d = PULSE;
                cnt_d   = 4'd0;
            end
            PULSE: begin
                if (cnt_q == 4'(PULSE_CYCLES - 1)) begin
                    // Last pulse cycle: sample completion and read data.
                    state_d = RECOVER;
                    if (port_q == PORT_D) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = we_q ? 32'h0 : sram_rdata;
                        d_err_d    = !sram_done;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = we_q ? 32'h0 : sram_rdata;
                        if_err_d    = !sram_done;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RECOVER: state_d = IDLE;
            ERRRESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and data registers; async reset kills any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_last_q   <= PORT_IF;
            port_q      <= PORT_IF;
            we_q        <= 1'b0;
            addr_q      <= 7'd0;
            mask_q      <= 4'd0;
            wdata_q     <= 32'h0;
            cnt_q       <= 4'd0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= 32'h0;
            if_err_q    <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= 32'h0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            port_q      <= port_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    // Macro bus comes straight from latched operands, so it cannot move mid-pulse.
    assign sram_addr        = addr_q;
    assign sram_byte_sel    = mask_q;
    assign sram_wdata       = wdata_q;
    assign sram_read_pulse  = (state_q == PULSE) && !we_q;
    assign sram_write_pulse = (state_q == PULSE) && we_q;

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural model of the pulse-driven macro.
module tb_sram_ctrl;

    localparam int PC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [6:0]  sram_addr;
    logic [3:0]  sram_byte_sel;
    logic [31:0] sram_wdata;
    logic        sram_read_pulse, sram_write_pulse, sram_done;
    logic [31:0] sram_rdata;
    logic [2:0]  dbg_state;

    logic        done_low = 1'b0;
    logic [31:0] mem [128];

    int checks = 0;
    int errors = 0;

    // Bus monitor counters (written only by the monitor process).
    int          wp_n = 0;
    int          rp_n = 0;
    int          viol_n = 0;
    logic [6:0]  last_wp_addr = 7'd0;
    logic [3:0]  last_wp_bsel = 4'd0;
    logic        prev_p = 1'b0;
    logic [42:0] prev_bus = '0;

    sram_ctrl #(.PULSE_CYCLES(PC), .DEPTH_WORDS(128)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .sram_addr(sram_addr), .sram_byte_sel(sram_byte_sel),
        .sram_wdata(sram_wdata), .sram_read_pulse(sram_read_pulse),
        .sram_write_pulse(sram_write_pulse), .sram_done(sram_done),
        .sram_rdata(sram_rdata), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Macro model: lane-masked writes during write_pulse, data out during read_pulse.
    initial for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    always @(posedge clk) begin
        if (sram_write_pulse) begin
            for (int b = 0; b < 4; b++)
                if (sram_byte_sel[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end
    assign sram_rdata = sram_read_pulse ? mem[sram_addr] : 32'h0;
    assign sram_done  = (sram_read_pulse || sram_write_pulse) && !done_low;

    // Bus monitor: pulse counts, overlap and stability while pulsing.
    always @(negedge clk) begin
        if (sram_read_pulse && sram_write_pulse) viol_n++;
        if ((sram_read_pulse || sram_write_pulse) && prev_p &&
            ({sram_addr, sram_byte_sel, sram_wdata} != prev_bus)) viol_n++;
        if (sram_write_pulse) begin
            wp_n++;
            last_wp_addr = sram_addr;
            last_wp_bsel = sram_byte_sel;
        end
        if (sram_read_pulse) rp_n++;
        prev_p   = sram_read_pulse || sram_write_pulse;
        prev_bus = {sram_addr, sram_byte_sel, sram_wdata};
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Drivers: entered #1 after a rising edge, return #1 after the grant edge.
    task automatic d_issue(input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int  n;
        bit  ok;
        d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
        n = 0; ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            n++;
            if (d_gnt) ok = 1'b1;
        end
        chk("d_gnt_seen", 32'(ok), 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic if_issue(input logic [31:0] addr);
        int  n;
        bit  ok;
        if_req = 1'b1; if_addr = addr;
        n = 0; ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            n++;
            if (if_gnt) ok = 1'b1;
        end
        chk("if_gnt_seen", 32'(ok), 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    // Latency counts cycles after the grant cycle; returns #1 after the next edge.
    task automatic wait_resp(input bit port, output logic [31:0] data,
                             output logic err, output int lat);
        bit found;
        found = 1'b0; lat = 0; data = 32'h0; err = 1'b0;
        while (!found && lat < 40) begin
            @(negedge clk);
            lat++;
            if (port ? d_rvalid : if_rvalid) begin
                found = 1'b1;
                data  = port ? d_rdata : if_rdata;
                err   = port ? d_err : if_err;
            end
        end
        chk("resp_seen", 32'(found), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, wp0, rp0, cnt, g, dn, cyc;
        int          order [3];
        int          gcyc [3];
        bit          gd, gi;

        // Reset, with a request pending that must not be granted.
        reset = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h0; d_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_d_gnt", 32'(d_gnt), 32'd0);
        chk("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        chk("rst_pulses", {30'd0, sram_read_pulse, sram_write_pulse}, 32'd0);
        chk("rst_bus", {21'd0, sram_addr, sram_byte_sel}, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        d_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Word write then port 0 read back.
        wp0 = wp_n; rp0 = rp_n;
        d_issue(1'b1, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF);
        wait_resp(1'b1, rd, er, lat);
        chk("w1_lat", 32'(lat), 32'(PC + 2));
        chk("w1_err", 32'(er), 32'd0);
        chk("w1_rdata_zero", rd, 32'h0);
        chk("w1_wp_cycles", 32'(wp_n - wp0), 32'(PC));
        chk("w1_rp_cycles", 32'(rp_n - rp0), 32'd0);
        chk("w1_addr", 32'(last_wp_addr), 32'd4);
        chk("w1_bsel", 32'(last_wp_bsel), 32'hF);
        if_issue(32'h0000_0010);
        wait_resp(1'b0, rd, er, lat);
        chk("r1_lat", 32'(lat), 32'(PC + 2));
        chk("r1_rdata", rd, 32'hDEAD_BEEF);
        chk("r1_err", 32'(er), 32'd0);

        // Byte write into lane 3, then full-word read merges it.
        d_issue(1'b1, 2'b00, 32'h0000_0013, 32'hAA00_0000);
        wait_resp(1'b1, rd, er, lat);
        chk("wb_bsel", 32'(last_wp_bsel), 32'h8);
        chk("wb_err", 32'(er), 32'd0);
        if_issue(32'h0000_0010);
        wait_resp(1'b0, rd, er, lat);
        chk("rb_rdata", rd, 32'hAAAD_BEEF);

        // Both ports request together; last winner was port 0.
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h0000_0010;
        g = 0; dn = 0; cyc = 0;
        for (int k = 0; k < 3; k++) begin order[k] = -1; gcyc[k] = 0; end
        while (g < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            gd = d_gnt; gi = if_gnt;
            if (gd || gi) begin
                order[g] = gd ? 1 : 0;
                gcyc[g]  = cyc;
                g++;
            end
            @(posedge clk); #1;
            if (gd) begin
                dn++;
                if (dn == 2) d_req = 1'b0;
            end
            if (gi) if_req = 1'b0;
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("arb_count", 32'(g), 32'd3);
        chk("arb_first_d", 32'(order[0]), 32'd1);
        chk("arb_second_if", 32'(order[1]), 32'd0);
        chk("arb_third_d", 32'(order[2]), 32'd1);
        chk("arb_gap1", 32'(gcyc[1] - gcyc[0]), 32'(PC + 3));
        chk("arb_gap2", 32'(gcyc[2] - gcyc[1]), 32'(PC + 3));
        repeat (PC + 4) @(posedge clk);
        #1;

        // Rejected accesses: next-cycle error response, macro untouched.
        wp0 = wp_n; rp0 = rp_n;
        d_issue(1'b0, 2'b01, 32'h0000_0021, 32'h0);
        wait_resp(1'b1, rd, er, lat);
        chk("half_mis_lat", 32'(lat), 32'd1);
        chk("half_mis_err", 32'(er), 32'd1);
        chk("half_mis_rdata", rd, 32'h0);
        d_issue(1'b1, 2'b10, 32'h0000_0200, 32'h1234_5678);
        wait_resp(1'b1, rd, er, lat);
        chk("range_lat", 32'(lat), 32'd1);
        chk("range_err", 32'(er), 32'd1);
        d_issue(1'b0, 2'b11, 32'h0000_0000, 32'h0);
        wait_resp(1'b1, rd, er, lat);
        chk("size11_err", 32'(er), 32'd1);
        chk("err_no_pulse", 32'((wp_n - wp0) + (rp_n - rp0)), 32'd0);
        // Last legal word is accepted.
        d_issue(1'b0, 2'b10, 32'h0000_01FC, 32'h0);
        wait_resp(1'b1, rd, er, lat);
        chk("top_word_err", 32'(er), 32'd0);
        chk("top_word_lat", 32'(lat), 32'(PC + 2));

        // Macro fails to signal completion.
        done_low = 1'b1;
        d_issue(1'b0, 2'b10, 32'h0000_0010, 32'h0);
        wait_resp(1'b1, rd, er, lat);
        done_low = 1'b0;
        chk("nodone_lat", 32'(lat), 32'(PC + 2));
        chk("nodone_err", 32'(er), 32'd1);

        // Reset during the second pulse cycle.
        d_issue(1'b0, 2'b10, 32'h0000_0010, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid_rp_before", 32'(sram_read_pulse), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_rp_drop", 32'(sram_read_pulse), 32'd0);
        chk("rst_mid_state", 32'(dbg_state), 32'd0);
        cnt = 0;
        repeat (2) begin
            @(negedge clk);
            cnt += int'(d_rvalid);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            cnt += int'(d_rvalid);
        end
        chk("rst_mid_no_resp", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        d_issue(1'b0, 2'b10, 32'h0000_0010, 32'h0);
        wait_resp(1'b1, rd, er, lat);
        chk("post_rst_rdata", rd, 32'hAAAD_BEEF);
        chk("post_rst_err", 32'(er), 32'd0);
        chk("post_rst_lat", 32'(lat), 32'(PC + 2));

        chk("bus_protocol", 32'(viol_n), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
